// File: rtl/fp32_accumulator.sv
// ============================================================================
// Module   : fp32_accumulator (with fp32_add)
// Brief    : Sums binary32 beats of a valid/ready group and presents the total.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_add (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, sticky, round_up, sign;
    logic [31:0] big, sml;
    logic [7:0]  e_big, e_sml, diff, shamt;
    logic [26:0] m_big, m_sml, m_aln, norm;
    logic [27:0] sum;
    logic [24:0] mant_r;
    logic [8:0]  exp_n, field;
    logic [22:0] frac;
    logic [4:0]  lz;

    always_comb begin
        a_nan   = (&a_i[30:23]) && (|a_i[22:0]);
        b_nan   = (&b_i[30:23]) && (|b_i[22:0]);
        a_inf   = (&a_i[30:23]) && !(|a_i[22:0]);
        b_inf   = (&b_i[30:23]) && !(|b_i[22:0]);
        swap    = b_i[30:0] > a_i[30:0];
        big     = swap ? b_i : a_i;
        sml     = swap ? a_i : b_i;
        // Subnormals use exponent 1 with no hidden bit
        e_big   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        e_sml   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        diff    = e_big - e_sml;
        m_big   = {|big[30:23], big[22:0], 3'b000};
        m_sml   = {|sml[30:23], sml[22:0], 3'b000};
        m_aln   = m_sml >> diff;
        sticky  = |(m_sml & ~({27{1'b1}} << diff));
        m_aln[0] = m_aln[0] | sticky;
        eff_sub = big[31] ^ sml[31];
        sum     = eff_sub ? ({1'b0, m_big} - {1'b0, m_aln})
                          : ({1'b0, m_big} + {1'b0, m_aln});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            shamt = 8'd0;
            exp_n = {1'b0, e_big} + 9'd1;
        end else begin
            // Left shift is capped so the exponent never drops below the subnormal one
            shamt = ({3'b000, lz} < e_big) ? {3'b000, lz} : (e_big - 8'd1);
            norm  = sum[26:0] << shamt;
            exp_n = {1'b0, e_big} - {1'b0, shamt};
        end

        round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            field = exp_n + 9'd1;
            frac  = 23'd0;
        end else begin
            field = mant_r[23] ? exp_n : 9'd0;
            frac  = mant_r[22:0];
        end
        sign = (sum == 28'd0) ? (big[31] & ~eff_sub) : big[31];

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) sum_o = 32'h7FC0_0000;
        else if (a_inf)                                    sum_o = a_i;
        else if (b_inf)                                    sum_o = b_i;
        else if (field >= 9'd255)                          sum_o = {sign, 8'hFF, 23'd0};
        else                                               sum_o = {sign, field[7:0], frac};
    end
endmodule

module fp32_accumulator #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_nan
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         acc_q, acc_d, add_res;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic                nan_q, nan_d, accept, in_nan;

    fp32_add u_add (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sum_o (add_res)
    );

    assign in_ready = (state_q != DONE) && !clr;
    assign accept   = in_valid && in_ready;
    assign in_nan   = (&in_data[30:23]) && (|in_data[22:0]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nan_d   = nan_q;
        if (clr) begin
            state_d = IDLE;
            acc_d   = 32'd0;
            cnt_d   = '0;
            nan_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = add_res;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);
                        nan_d   = nan_q | in_nan | (add_res == 32'h7FC0_0000);
                        state_d = in_last ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = 32'd0;
                        cnt_d   = '0;
                        nan_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            cnt_q   <= '0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            nan_q   <= nan_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_nan   = nan_q;
endmodule

`default_nettype wire

// File: tb/tb_fp32_accumulator.sv
// ============================================================================
// Module   : tb_fp32_accumulator
// Brief    : Randomized scoreboard bench for fp32_accumulator with a real-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp32_accumulator;
    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_last, out_ready;
    logic        in_ready, out_valid, out_nan;
    logic [31:0] in_data, out_data;
    logic [15:0] out_count;

    logic        s_clr, s_in_valid, s_in_last, s_out_ready;
    logic        s_in_ready, s_out_valid, s_out_nan;
    logic [31:0] s_in_data, s_out_data;
    logic [1:0]  s_out_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 1;
    logic [48:0] sb[$];

    always #5 clk = ~clk;

    fp32_accumulator #(.COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_nan(out_nan)
    );

    fp32_accumulator #(.COUNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(s_clr),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_count(s_out_count), .out_nan(s_out_nan)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic bit is_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    endfunction

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        e = int'(f[30:23]);
        m = real'(int'(f[22:0]));
        if (e == 0) m = m * (2.0 ** (-149));
        else        m = (m + 8388608.0) * (2.0 ** (e - 150));
        return f[31] ? -m : m;
    endfunction

    // Round a double to the nearest binary32, ties to even, with subnormals.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0]     b;
        longint unsigned m, kept, rem, half, res;
        int              fe, sh;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        fe = int'(b[62:52]) - 1023 + 127;
        if (fe >= 255) return {b[63], 8'hFF, 23'd0};
        m  = {11'd0, 1'b1, b[51:0]};
        sh = (fe >= 1) ? 29 : 29 + 1 - fe;
        if (sh > 54) return {b[63], 31'd0};
        kept = m >> sh;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        res = (fe >= 1) ? (longint'(fe - 1) << 23) + kept : kept;
        if (res >= 64'h7F80_0000) res = 64'h7F80_0000;
        return {b[63], res[30:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return 32'h7FC0_0000;
        if (is_inf(a) && is_inf(b)) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        int          k;
        logic [31:0] r;
        k = $urandom_range(0, 9);
        r = $urandom;
        if (k < 3) return r;
        if (k < 7) return {r[31], 8'(120 + $urandom_range(0, 15)), r[22:0]};
        if (k == 7) return {r[31], 8'd0, r[22:0]};
        if (k == 8) return {r[31], 8'hFE, r[22:0]};
        case ($urandom_range(0, 3))
            0:       return 32'h7F80_0000;
            1:       return 32'hFF80_0000;
            2:       return 32'h7F80_0001;
            default: return {r[31], 31'd0};
        endcase
    endfunction

    // ---------------- drivers ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit ok = 0;
        int t  = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = l;
            #1;
            if (in_ready) begin
                ok = 1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            t++;
        end
        chk("beat_accepted", 64'(ok), 64'd1);
    endtask

    task automatic run_group(input logic [31:0] beats[$], input int max_gap, input bit chk_lat);
        logic [31:0] acc = 32'd0;
        logic [15:0] cnt = 16'd0;
        logic        nan = 1'b0;
        foreach (beats[i]) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_beat(beats[i], i == beats.size() - 1);
            acc = ref_add(acc, beats[i]);
            cnt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            nan = nan | is_nan(beats[i]) | (acc == 32'h7FC0_0000);
        end
        sb.push_back({nan, cnt, acc});
        if (chk_lat) begin
            @(negedge clk);
            chk("latency_out_valid", 64'(out_valid), 64'd1);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [48:0] e, prev;
        bit          pending = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pending) begin
                    chk("hold_out_valid", 64'(out_valid), 64'd1);
                    chk("hold_out_fields", {15'd0, out_nan, out_count, out_data}, {15'd0, prev});
                end
                pending = out_valid && !out_ready;
                prev    = {out_nan, out_count, out_data};
                if (out_valid && out_ready) begin
                    chk("scoreboard_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("out_data",  64'(out_data),  64'(e[31:0]));
                        chk("out_count", 64'(out_count), 64'(e[47:32]));
                        chk("out_nan",   64'(out_nan),   64'(e[48]));
                    end
                end
            end else begin
                pending = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] q[$];
        logic [1:0]  sc;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000; in_last = 1'b0;
        s_clr = 1'b0; s_in_valid = 1'b0; s_in_data = 32'd0; s_in_last = 1'b0; s_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_nan",   64'(out_nan),   64'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // sum, single beat
        q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        run_group(q, 0, 1);
        q = '{32'hBF80_0000};
        run_group(q, 0, 1);

        // backpressure
        rdy_mode = 2;
        q = '{32'h4040_0000, 32'h3F00_0000};
        run_group(q, 0, 0);
        in_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            #1;
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data",  64'(out_data),  64'(sb[0][31:0]));
        end
        rdy_mode = 1;
        @(negedge clk);
        #1;
        chk("done_handshake_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_in_ready",  64'(in_ready),  64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        q = '{32'h3F80_0000};
        run_group(q, 0, 1);

        // NaN / infinity, then a clean group
        q = '{32'h7F80_0000, 32'hFF80_0000};
        run_group(q, 0, 1);
        q = '{32'h3F80_0000};
        run_group(q, 0, 1);

        // abort with clr, then reset mid-group
        send_beat(32'h3F80_0000, 1'b0);
        send_beat(32'h4000_0000, 1'b0);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_data = 32'h4000_0000; in_last = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("clr_out_count", 64'(out_count), 64'd0);
        chk("clr_out_data",  64'(out_data),  64'd0);
        send_beat(32'h3F80_0000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_out_valid", 64'(out_valid), 64'd0);
            chk("abort_out_count",    64'(out_count), 64'd0);
        end
        q = '{32'h4000_0000};
        run_group(q, 0, 1);

        // randomized groups under random backpressure
        rdy_mode = 0;
        for (int g = 0; g < 40; g++) begin
            q.delete();
            for (int b = 0; b < $urandom_range(1, 6); b++) q.push_back(rand_fp());
            run_group(q, 2, 0);
        end

        // saturation on the narrow-counter instance
        sc = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            s_in_data  = 32'd0;
            s_in_last  = (i == 4);
            #1;
            chk("sat_in_ready", 64'(s_in_ready), 64'd1);
            sc = (sc == 2'd3) ? sc : sc + 2'd1;
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("sat_out_valid", 64'(s_out_valid), 64'd1);
        chk("sat_out_count", 64'(s_out_count), 64'(sc));
        chk("sat_out_data",  64'(s_out_data),  64'd0);
        chk("sat_out_nan",   64'(s_out_nan),   64'd0);

        rdy_mode = 1;
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fp32_accumulator.md
FP32_ACCUMULATOR -- requirements
Module: fp32_accumulator

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, the width of the beat counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port clr, input, 1, a synchronous abort of the group in progress.
REQ-005 SHALL have port in_valid, input, 1, meaning an input beat is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept a beat.
REQ-007 SHALL have port in_data, input, 32, the IEEE-754 binary32 operand.
REQ-008 SHALL have port in_last, input, 1, marking the final beat of a group.
REQ-009 SHALL have port out_valid, output, 1, meaning the group result is presented.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port out_data, output, 32, the binary32 group sum.
REQ-012 SHALL have port out_count, output, COUNT_W, the number of beats in the group.
REQ-013 SHALL have port out_nan, output, 1, set if any beat or partial sum of the group was NaN.

Function
REQ-014 SHALL instantiate the team fp32 adder combinationally, with operand a = acc_q and operand b = in_data; the adder result is registered only on an accepted beat.
REQ-015 SHALL implement the states IDLE, ACCUM and DONE; IDLE means acc_q = 32'h00000000 and the count is 0.
REQ-016 A beat SHALL be accepted on a cycle where in_valid && in_ready is true; in_ready = (state != DONE) && !clr.
REQ-017 On an accepted beat without in_last: acc_q <= adder result; the count increments; the state becomes ACCUM.
REQ-018 On an accepted beat with in_last: acc_q <= adder result; the count increments; the state becomes DONE; out_valid is asserted the next cycle, so latency is 1 cycle from the last beat.
REQ-019 In DONE: out_data = acc_q, out_count = the count, and out_nan = the sticky NaN flag; all three are stable while out_valid && !out_ready.
REQ-020 In DONE with out_ready = 1: out_valid deasserts the next cycle; acc_q, the count and the NaN flag clear; the state becomes IDLE.
REQ-021 No beat SHALL be accepted in the DONE state, including the cycle in which out_ready = 1; the first beat of the next group is accepted one cycle later at the earliest.
REQ-022 The count SHALL saturate at 2^COUNT_W-1 and SHALL NOT wrap.
REQ-023 The NaN flag SHALL be set on an accepted beat when in_data is NaN (exp = 8'hFF, mantissa != 0) or when the adder result is 32'h7FC00000; it stays set until the group is consumed or cleared.
REQ-024 Infinity and overflow results SHALL propagate exactly as the adder produces them, with no additional rounding or flushing.
REQ-025 clr = 1 in any state SHALL force IDLE and clear acc_q, the count, the NaN flag and out_valid on the next edge; the beat offered in that cycle SHALL be dropped.
REQ-026 A group of exactly one beat (in_last on the first beat) SHALL yield out_data = 0 + in_data as computed by the adder.
REQ-027 The output side SHALL NOT depend combinationally on in_valid, and the input side SHALL NOT depend combinationally on out_ready.

Reset
REQ-028 When rst_n = 0 at a clock edge, the block SHALL enter IDLE with acc_q = 0, count = 0, out_valid = 0, out_data = 32'h00000000, out_count = 0 and out_nan = 0.
REQ-029 Reset SHALL take priority over clr and over all handshakes.
REQ-030 Reset asserted mid-group or in DONE SHALL discard the partial result; no out_valid SHALL follow for the discarded group.
REQ-031 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-032 Sum: beats 3F800000, 40000000, 40400000 (last), out_ready = 1 -> out_valid one cycle after the last beat with out_data = 40C00000, out_count = 3, out_nan = 0.
REQ-033 Single beat: BF800000 with in_last -> out_data = BF800000, out_count = 1.
REQ-034 Backpressure: result pending with out_ready = 0 for 3 cycles and in_valid held high -> in_ready = 0 throughout, out_data stable; out_ready = 1 -> IDLE, and the next beat is accepted one cycle later.
REQ-035 NaN and inf: beats 7F800000 then FF800000 (last) -> out_data = 7FC00000, out_nan = 1; the next group 3F800000 (last) -> out_nan = 0.
REQ-036 Abort: clr pulsed after 2 beats, then rst_n pulsed mid-group -> no out_valid; a subsequent group 40000000 (last) -> out_data = 40000000, out_count = 1.
REQ-037 Saturation with COUNT_W = 2: 5 beats of 00000000 -> out_count = 3, out_data = 00000000.
